// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one pipelined FP multiplier among N_REQ requesters,
// registering operands on issue and routing each result back to the requester that issued it.
module fp_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [4*N_REQ-1:0]    req_r_mode,
  input  logic [32*N_REQ-1:0]   req_fp_X,
  input  logic [32*N_REQ-1:0]   req_fp_Y,
  output logic                  mul_valid,
  output logic [3:0]            mul_r_mode,
  output logic [31:0]           mul_fp_X,
  output logic [31:0]           mul_fp_Y,
  input  logic [31:0]           mul_fp_Z,
  input  logic                  mul_ovrf,
  input  logic                  mul_udrf,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_fp_Z,
  output logic                  rsp_ovrf,
  output logic                  rsp_udrf,
  output logic [15:0]           ops_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] ptr_next;
  logic             found;
  logic             handshake;
  logic [IDX_W:0]   cand;
  logic [3:0]       sel_r_mode;
  logic [31:0]      sel_fp_X;
  logic [31:0]      sel_fp_Y;

  logic [MUL_LAT:0] tag_valid;
  logic [IDX_W-1:0] tag_owner [0:MUL_LAT];
  logic             last_valid;
  logic [IDX_W-1:0] last_owner;

  // Search upward from ptr, wrapping at N_REQ, for the first valid requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

  assign handshake = found & ~rst;
  assign ptr_next  = (grant == IDX_W'(N_REQ-1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant] = 1'b1;
  end

  always_comb begin
    sel_r_mode = '0;
    sel_fp_X   = '0;
    sel_fp_Y   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_r_mode = req_r_mode[4*i +: 4];
        sel_fp_X   = req_fp_X[32*i +: 32];
        sel_fp_Y   = req_fp_Y[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid  <= 1'b0;
      mul_r_mode <= '0;
      mul_fp_X   <= '0;
      mul_fp_Y   <= '0;
    end else begin
      mul_valid <= handshake;
      if (handshake) begin
        mul_r_mode <= sel_r_mode;
        mul_fp_X   <= sel_fp_X;
        mul_fp_Y   <= sel_fp_Y;
      end
    end
  end

  // Stage 0 lines up with mul_valid; the last stage lines up with the multiplier result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      for (int i = 0; i <= MUL_LAT; i++) tag_owner[i] <= '0;
    end else begin
      tag_valid[0] <= handshake;
      tag_owner[0] <= grant;
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign last_valid = tag_valid[MUL_LAT];
  assign last_owner = tag_owner[MUL_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_fp_Z  <= '0;
      rsp_ovrf  <= 1'b0;
      rsp_udrf  <= 1'b0;
      ops_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid[i] <= last_valid && (last_owner == IDX_W'(i));
      end
      if (last_valid) begin
        rsp_fp_Z  <= mul_fp_Z;
        rsp_ovrf  <= mul_ovrf;
        rsp_udrf  <= mul_udrf;
        ops_count <= ops_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a small truncating FP multiplier model behind it.
module tb_fp_mul_arbiter;
  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 2;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [4*N_REQ-1:0]  req_r_mode;
  logic [32*N_REQ-1:0] req_fp_X;
  logic [32*N_REQ-1:0] req_fp_Y;
  logic                mul_valid;
  logic [3:0]          mul_r_mode;
  logic [31:0]         mul_fp_X;
  logic [31:0]         mul_fp_Y;
  logic [31:0]         mul_fp_Z;
  logic                mul_ovrf;
  logic                mul_udrf;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_fp_Z;
  logic                rsp_ovrf;
  logic                rsp_udrf;
  logic [15:0]         ops_count;

  int tests_run    = 0;
  int tests_failed = 0;

  fp_mul_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_r_mode(req_r_mode),
    .req_fp_X(req_fp_X), .req_fp_Y(req_fp_Y),
    .mul_valid(mul_valid), .mul_r_mode(mul_r_mode), .mul_fp_X(mul_fp_X), .mul_fp_Y(mul_fp_Y),
    .mul_fp_Z(mul_fp_Z), .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
    .rsp_valid(rsp_valid), .rsp_fp_Z(rsp_fp_Z), .rsp_ovrf(rsp_ovrf), .rsp_udrf(rsp_udrf),
    .ops_count(ops_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Normal-range single-precision multiply with truncation; returns {ovrf, udrf, Z}.
  function automatic logic [33:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] prod;
    logic [22:0] mant;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {2'b00, s, 31'd0};
    prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (prod[47]) begin
      mant = prod[46:24];
      e = e + 1;
    end else begin
      mant = prod[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], mant};
  endfunction

  logic [33:0] mpipe [0:MUL_LAT-1];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_fp_X, mul_fp_Y);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign {mul_ovrf, mul_udrf, mul_fp_Z} = mpipe[MUL_LAT-1];

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic set_op(input int idx, input logic [3:0] rm, input logic [31:0] x, input logic [31:0] y);
    req_r_mode[4*idx +: 4] = rm;
    req_fp_X[32*idx +: 32] = x;
    req_fp_Y[32*idx +: 32] = y;
  endtask

  // Presents one op for one cycle; returns at the negedge of the cycle after the handshake.
  task automatic send(input int idx, input logic [3:0] rm, input logic [31:0] x, input logic [31:0] y,
                      output logic [N_REQ-1:0] rdy);
    @(negedge clk);
    set_op(idx, rm, x, y);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
  endtask

  // Latency counted in cycles from the handshake cycle; -1 if nothing shows up.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int n = 2; n <= 12; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_r_mode = '0;
    req_fp_X = '0;
    req_fp_Y = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({mul_valid, mul_r_mode, mul_fp_X, mul_fp_Y, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got mul_valid=%b X=%h Y=%h rsp_valid=%b Z=%h ops=%h, expected all zero",
               mul_valid, mul_fp_X, mul_fp_Y, rsp_valid, rsp_fp_Z, ops_count);
    end
    req_valid = 4'hF;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL ready_in_reset: got %b, expected 0000", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    logic [N_REQ-1:0] rdy;
    int lat;
    send(1, 4'h0, 32'h3FC00000, 32'h40000000, rdy);
    tests_run++;
    if (rdy !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL single_ready: got %b, expected 0010", rdy);
    end
    tests_run++;
    if ({mul_valid, mul_fp_X, mul_fp_Y} !== {1'b1, 32'h3FC00000, 32'h40000000}) begin
      tests_failed++;
      $display("[TB] FAIL single_issue: got v=%b X=%h Y=%h, expected v=1 X=3fc00000 Y=40000000",
               mul_valid, mul_fp_X, mul_fp_Y);
    end
    wait_rsp(lat);
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("[TB] FAIL single_latency: got %0d, expected 4", lat);
    end
    tests_run++;
    if ({rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count} !== {4'b0010, 32'h40400000, 2'b00, 16'd1}) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got v=%b Z=%h o=%b u=%b ops=%0d, expected v=0010 Z=40400000 o=0 u=0 ops=1",
               rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count);
    end
  endtask

  task automatic test_fairness();
    logic [31:0]      fair_y [4];
    logic [N_REQ-1:0] exp_v;
    fair_y = '{32'h40010000, 32'h40020000, 32'h40030000, 32'h40040000};
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_op(i, 4'h0, 32'h3F800000, fair_y[i]);
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        exp_v = 4'(1 << (c % 4));
        tests_run++;
        if (req_ready !== exp_v) begin
          tests_failed++;
          $display("[TB] FAIL fair_grant_%0d: got %b, expected %b", c, req_ready, exp_v);
        end
      end
      exp_v = (c >= 4) ? 4'(1 << ((c - 4) % 4)) : 4'b0000;
      tests_run++;
      if (rsp_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL fair_rsp_%0d: got %b, expected %b", c, rsp_valid, exp_v);
      end
      if (c >= 4) begin
        tests_run++;
        if (rsp_fp_Z !== fair_y[(c - 4) % 4]) begin
          tests_failed++;
          $display("[TB] FAIL fair_data_%0d: got %h, expected %h", c, rsp_fp_Z, fair_y[(c - 4) % 4]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (ops_count !== 16'd8) begin
      tests_failed++;
      $display("[TB] FAIL fair_count: got %0d, expected 8", ops_count);
    end
  endtask

  task automatic test_flags();
    logic [N_REQ-1:0] rdy;
    int lat;
    send(3, 4'h3, 32'h7F000000, 32'h7F000000, rdy);
    tests_run++;
    if ({rdy, mul_r_mode} !== {4'b1000, 4'h3}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_issue: got ready=%b rmode=%h, expected ready=1000 rmode=3", rdy, mul_r_mode);
    end
    wait_rsp(lat);
    tests_run++;
    if ({lat == 4, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf} !== {1'b1, 4'b1000, 32'h7F800000, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL ovf_result: got lat=%0d v=%b Z=%h o=%b u=%b, expected lat=4 v=1000 Z=7f800000 o=1 u=0",
               lat, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf);
    end
    send(1, 4'h5, 32'h00800000, 32'h00800000, rdy);
    tests_run++;
    if (rdy !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL udf_ready: got %b, expected 0010", rdy);
    end
    wait_rsp(lat);
    tests_run++;
    if ({lat == 4, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count} !== {1'b1, 4'b0010, 32'h0, 2'b01, 16'd10}) begin
      tests_failed++;
      $display("[TB] FAIL udf_result: got lat=%0d v=%b Z=%h o=%b u=%b ops=%0d, expected lat=4 v=0010 Z=0 o=0 u=1 ops=10",
               lat, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count);
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      tests_run++;
      if ({req_ready, mul_valid, rsp_valid} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL idle_strobes_%0d: got ready=%b mv=%b rv=%b, expected zeros", c, req_ready, mul_valid, rsp_valid);
      end
      tests_run++;
      if ({mul_r_mode, mul_fp_X, mul_fp_Y, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count} !==
          {4'h5, 32'h00800000, 32'h00800000, 32'h0, 2'b01, 16'd10}) begin
        tests_failed++;
        $display("[TB] FAIL idle_data_%0d: got rm=%h X=%h Y=%h Z=%h o=%b u=%b ops=%0d, expected values held",
                 c, mul_r_mode, mul_fp_X, mul_fp_Y, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count);
      end
    end
    req_valid = 4'hF;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL idle_ptr: got %b, expected 0100", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    logic [N_REQ-1:0] exp_g [3];
    logic [N_REQ-1:0] rdy;
    int seen;
    int lat;
    exp_g = '{4'b0100, 4'b0001, 4'b0010};
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_op(i, 4'h0, 32'h3F800000, 32'h40100000 + 32'(i));
    req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++;
      if (req_ready !== exp_g[c]) begin
        tests_failed++;
        $display("[TB] FAIL midrst_grant_%0d: got %b, expected %b", c, req_ready, exp_g[c]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ready: got %b, expected 0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    tests_run++;
    if ({mul_valid, mul_r_mode, mul_fp_X, mul_fp_Y, rsp_valid, rsp_fp_Z, rsp_ovrf, rsp_udrf, ops_count} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_state: got mv=%b X=%h rv=%b Z=%h ops=%h, expected all zero",
               mul_valid, mul_fp_X, rsp_valid, rsp_fp_Z, ops_count);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_stale_rsp: got %0d strobes, expected 0", seen);
    end
    req_valid = 4'hF;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL midrst_ptr: got %b, expected 0001", req_ready);
    end
    req_valid = '0;
    send(2, 4'h0, 32'h3FC00000, 32'h40000000, rdy);
    wait_rsp(lat);
    tests_run++;
    if ({rdy, lat == 4, rsp_valid, rsp_fp_Z, ops_count} !== {4'b0100, 1'b1, 4'b0100, 32'h40400000, 16'd1}) begin
      tests_failed++;
      $display("[TB] FAIL midrst_next_op: got rdy=%b lat=%0d v=%b Z=%h ops=%0d, expected rdy=0100 lat=4 v=0100 Z=40400000 ops=1",
               rdy, lat, rsp_valid, rsp_fp_Z, ops_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_REQ-1:0] exp_v;
    @(negedge clk);
    req_valid = 4'b1000;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) set_op(3, 4'h0, 32'h3F800000, 32'h40800000 + 32'(c));
      else req_valid = '0;
      #1;
      if (c < 5) begin
        tests_run++;
        if (req_ready !== 4'b1000) begin
          tests_failed++;
          $display("[TB] FAIL b2b_grant_%0d: got %b, expected 1000", c, req_ready);
        end
      end
      exp_v = (c >= 4) ? 4'b1000 : 4'b0000;
      tests_run++;
      if (rsp_valid !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rsp_%0d: got %b, expected %b", c, rsp_valid, exp_v);
      end
      if (c >= 4) begin
        tests_run++;
        if (rsp_fp_Z !== 32'h40800000 + 32'(c - 4)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_data_%0d: got %h, expected %h", c, rsp_fp_Z, 32'h40800000 + 32'(c - 4));
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (ops_count !== 16'd6) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d, expected 6", ops_count);
    end
  endtask

  task automatic test_counter_wrap();
    int done;
    do_reset();
    set_op(0, 4'h0, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b0001;
    done = 0;
    for (int c = 0; c < 65537 + 10; c++) begin
      if (c == 65537) req_valid = '0;
      #1;
      if (rsp_valid[0]) begin
        done++;
        if (done == 65535) begin
          tests_run++;
          if (ops_count !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL wrap_ffff: got %h, expected ffff", ops_count);
          end
        end
        if (done == 65536) begin
          tests_run++;
          if (ops_count !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_zero: got %h, expected 0000", ops_count);
          end
        end
        if (done == 65537) begin
          tests_run++;
          if (ops_count !== 16'h0001) begin
            tests_failed++;
            $display("[TB] FAIL wrap_one: got %h, expected 0001", ops_count);
          end
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (done !== 65537) begin
      tests_failed++;
      $display("[TB] FAIL wrap_completions: got %0d, expected 65537", done);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_flags();
    test_idle_hold();
    test_reset_midflight();
    test_back_to_back();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
